multi_channel_output_serializer: RTL and testbench
==================================================

MULTI_CHANNEL_OUTPUT_SERIALIZER -- requirements
Module: multi_channel_output_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, which sets the SRAM word width and the bits shifted out per word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, which sets the SRAM read address width.
REQ-003 SHALL have parameter NUM_CH, default 4, which sets the number of selectable SRAM read channels.
REQ-004 SHALL have parameter SEL_WIDTH, default 2, which sets the channel select width (ceil(log2(NUM_CH))).
REQ-005 SHALL have parameter RD_LATENCY, default 1, which sets the SRAM read latency in cycles (1..4).
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port debug_en, input, 1 bit, asynchronous to the block: the dump request.
REQ-009 SHALL have port sram_select, input, SEL_WIDTH bits: the channel to dump.
REQ-010 SHALL have port word_count, input, ADDR_WIDTH+1 bits: the number of words to dump.
REQ-011 SHALL have port msb_first, input, 1 bit: bit order (0 = LSB first).
REQ-012 SHALL have port hold, input, 1 bit: back-pressure that pauses the shift.
REQ-013 SHALL have port rd_en, output, 1 bit: the SRAM read strobe.
REQ-014 SHALL have port rd_addr, output, ADDR_WIDTH bits: the SRAM read address.
REQ-015 SHALL have port rd_data, input, NUM_CH*DATA_WIDTH bits: channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-016 SHALL have port serial_out, output, 1 bit: the serial data.
REQ-017 SHALL have port serial_out_valid, output, 1 bit: high when serial_out carries a data bit.
REQ-018 SHALL have port dump_done, output, 1 bit: a one-cycle pulse at the end of a dump.

Function
REQ-019 SHALL synchronise debug_en through two flops; every use below means the synchronised signal (en_s).
REQ-020 SHALL implement the states IDLE, FETCH, SHIFT and DONE.
REQ-021 SHALL, in IDLE on the rising edge of en_s, latch sram_select, word_count and msb_first, clear rd_addr to 0, and go to FETCH (or to DONE if word_count==0).
REQ-022 SHALL, in FETCH, pulse rd_en for one cycle, wait RD_LATENCY cycles, load the selected channel's word into the shift register, then go to SHIFT.
REQ-023 SHALL, in SHIFT, assert serial_out_valid and output one bit per cycle: bit 0 upward when msb_first=0, bit DATA_WIDTH-1 downward when msb_first=1.
REQ-024 SHALL prefetch the next word during SHIFT (issued RD_LATENCY+1 cycles before the word ends, into a holding register) so consecutive words stream with no valid gap.
REQ-025 SHALL increment rd_addr by 1 per word read, with wrap-around from 2^ADDR_WIDTH-1 to 0.
REQ-026 SHALL allow a word_count of 2^ADDR_WIDTH, which dumps the whole memory.
REQ-027 SHALL, while hold=1 in SHIFT, freeze the shift register, the bit counter and prefetch issue, deassert serial_out_valid, and keep serial_out stable.
REQ-028 SHALL capture a prefetch already in flight when hold rises and not lose it.
REQ-029 SHALL, after the last bit of the last word, enter DONE, pulse dump_done for one cycle, and then stay in DONE with valid=0 until en_s falls.
REQ-030 SHALL, on en_s falling in any state, abort to IDLE next cycle with rd_addr=0, valid=0, rd_en=0, and no dump_done.
REQ-031 SHALL ignore changes to sram_select, word_count and msb_first during a dump.
REQ-032 SHALL treat a selected channel index >= NUM_CH as output 0 data, with normal timing.

Reset
REQ-033 SHALL, while rst_n=0, hold asynchronously: state=IDLE, synchroniser flops=0, rd_addr=0, rd_en=0, serial_out=0, serial_out_valid=0, dump_done=0, and shift/holding registers=0.
REQ-034 SHALL, after reset, require a fresh rising edge of en_s to start a dump; debug_en held high through reset SHALL start a dump after the synchroniser fills.

Verification
REQ-035 SHALL cover: NUM_CH=4, ch2 words 0x1234 and 0xABCD, word_count=2, msb_first=0 -> 32 contiguous valid bits, LSB first, dump_done once.
REQ-036 SHALL cover: the same data with msb_first=1 -> the first bits are 0,0,0,1 (0x1234 MSB first).
REQ-037 SHALL cover: hold=1 for 5 cycles mid-word -> valid low for 5 cycles and the bit sequence is unchanged.
REQ-038 SHALL cover: RD_LATENCY=3 with word_count=4096 -> 65536 gapless valid bits, rd_addr wraps to 0, and 4096 rd_en pulses.
REQ-039 SHALL cover: debug_en dropped after 7 bits -> valid=0 within 3 cycles, no dump_done, and a re-raise restarts at address 0.
REQ-040 SHALL cover: word_count=0 -> no rd_en, no valid, and dump_done pulses once.

Source files
------------

// File: rtl/multi_channel_output_serializer.sv
// Dumps one SRAM read channel as a serial bitstream on a debug request, streaming
// consecutive words gaplessly by prefetching the next word into a holding register.
module multi_channel_output_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_CH     = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         debug_en,
    input  logic [SEL_WIDTH-1:0]         sram_select,
    input  logic [ADDR_WIDTH:0]          word_count,
    input  logic                         msb_first,
    input  logic                         hold,
    output logic                         rd_en,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
    output logic                         serial_out,
    output logic                         serial_out_valid,
    output logic                         dump_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    // Prefetch request is registered, so it is raised one bit earlier than the
    // cycle rd_en must be seen; data then lands one bit before the word ends.
    localparam logic [CNT_W-1:0] PF_BIT   = CNT_W'(DATA_WIDTH - 3 - RD_LATENCY);

    logic [1:0]            r_sync;
    logic                  r_en_d;
    logic [1:0]            r_state;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic [ADDR_WIDTH:0]   r_words_left;
    logic                  r_msb;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [RD_LATENCY:1]   r_vld_pipe;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] r_hold_word;
    logic [CNT_W-1:0]      r_bitcnt;
    logic                  r_done;

    logic                  w_en_s;
    logic                  w_start;
    logic                  w_ret;
    logic                  w_bit_go;
    logic                  w_more;
    logic [DATA_WIDTH-1:0] w_ch_word;

    assign w_en_s   = r_sync[1];
    assign w_start  = w_en_s & ~r_en_d;
    assign w_ret    = r_vld_pipe[RD_LATENCY];
    assign w_bit_go = (r_state == S_SHIFT) & ~hold;
    assign w_more   = r_words_left > (ADDR_WIDTH+1)'(1);

    // Out-of-range channel selects read as zero.
    always_comb begin
        w_ch_word = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (r_sel == SEL_WIDTH'(c)) w_ch_word = rd_data[c*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_en_d <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], debug_en};
            r_en_d <= w_en_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_sel        <= '0;
            r_words_left <= '0;
            r_msb        <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_vld_pipe   <= '0;
            r_shreg      <= '0;
            r_hold_word  <= '0;
            r_bitcnt     <= '0;
            r_done       <= 1'b0;
        end else begin
            r_rd_en       <= 1'b0;
            r_done        <= 1'b0;
            r_vld_pipe[1] <= r_rd_en;
            for (int k = 2; k <= RD_LATENCY; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
            if (r_rd_en) r_rd_addr <= r_rd_addr + 1'b1;

            if (r_state != S_IDLE && !w_en_s) begin
                // Abort drops any read still in flight so a restart cannot see it.
                r_state    <= S_IDLE;
                r_rd_addr  <= '0;
                r_vld_pipe <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_start) begin
                        r_sel        <= sram_select;
                        r_msb        <= msb_first;
                        r_words_left <= word_count;
                        r_rd_addr    <= '0;
                        if (word_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                            r_rd_en <= 1'b1;
                        end
                    end
                    S_FETCH: if (w_ret) begin
                        r_shreg  <= w_ch_word;
                        r_bitcnt <= '0;
                        r_state  <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (w_ret) r_hold_word <= w_ch_word;
                        if (w_bit_go) begin
                            if (r_bitcnt == PF_BIT && w_more) r_rd_en <= 1'b1;
                            if (r_bitcnt == LAST_BIT) begin
                                if (w_more) begin
                                    r_shreg      <= r_hold_word;
                                    r_bitcnt     <= '0;
                                    r_words_left <= r_words_left - 1'b1;
                                end else begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_shreg  <= r_msb ? {r_shreg[DATA_WIDTH-2:0], 1'b0}
                                                  : {1'b0, r_shreg[DATA_WIDTH-1:1]};
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end
                        end
                    end
                    S_DONE:  ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign rd_en            = r_rd_en;
    assign rd_addr          = r_rd_addr;
    assign serial_out       = r_msb ? r_shreg[DATA_WIDTH-1] : r_shreg[0];
    assign serial_out_valid = w_bit_go;
    assign dump_done        = r_done;

endmodule

// File: tb/tb_multi_channel_output_serializer.sv
// Randomised bench: an SRAM model with fixed read latency feeds the serializer and the
// received bitstream is compared with the word sequence expected from memory contents.
module tb_multi_channel_output_serializer;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int NC = 4;
    localparam int L  = 3;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              debug_en;
    logic [1:0]        sram_select;
    logic [AW:0]       word_count;
    logic              msb_first;
    logic              hold;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [NC*DW-1:0]  rd_data;
    logic              serial_out;
    logic              serial_out_valid;
    logic              dump_done;

    multi_channel_output_serializer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC), .SEL_WIDTH(2), .RD_LATENCY(L)
    ) dut (
        .clk(clk), .rst_n(rst_n), .debug_en(debug_en), .sram_select(sram_select),
        .word_count(word_count), .msb_first(msb_first), .hold(hold), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .serial_out(serial_out),
        .serial_out_valid(serial_out_valid), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    // SRAM model: data for a read appears L cycles after the rd_en cycle, junk otherwise.
    logic [DW-1:0]    mem [NC][DEPTH];
    logic [L-1:0]     pv = '0;
    logic [AW-1:0]    pa [L];
    logic [NC*DW-1:0] junk = '0;

    always @(posedge clk) begin
        pv    <= {pv[L-2:0], rd_en};
        pa[0] <= rd_addr;
        for (int k = 1; k < L; k++) pa[k] <= pa[k-1];
        junk  <= {$urandom, $urandom};
    end

    assign rd_data = pv[L-1] ? {mem[3][pa[L-1]], mem[2][pa[L-1]], mem[1][pa[L-1]], mem[0][pa[L-1]]}
                             : junk;

    int n_tests = 0;
    int n_fail  = 0;

    bit q_bits[$];
    bit q_exp[$];
    int n_rden, n_done, n_gaps, hold_unstable, late_valid, first_addr, end_addr;
    bit timed_out;

    task automatic build_exp(input int sel, input int wc, input bit msb, input int start);
        logic [DW-1:0] word;
        q_exp.delete();
        for (int w = 0; w < wc; w++) begin
            word = (sel < NC) ? mem[sel][(start + w) % DEPTH] : '0;
            for (int b = 0; b < DW; b++) q_exp.push_back(msb ? word[DW-1-b] : word[b]);
        end
    endtask

    function automatic int count_diff();
        int d = 0;
        for (int i = 0; i < q_bits.size() && i < q_exp.size(); i++)
            if (q_bits[i] !== q_exp[i]) d++;
        return d;
    endfunction

    task automatic run_dump(input int sel, input int wc, input bit msb, input int hold_at,
                            input int hold_len, input int abort_at, input bit scramble,
                            input int budget);
        int hold_left = 0, since_valid = 0, post_done = 0, drop_cyc = 0;
        bit seen = 0, hold_started = 0, aborted = 0, hv_set = 0, hv = 0;
        q_bits.delete();
        n_rden = 0; n_done = 0; n_gaps = 0; hold_unstable = 0; late_valid = 0;
        first_addr = -1; timed_out = 1;
        sram_select = 2'(sel); word_count = (AW+1)'(wc); msb_first = msb; hold = 0;
        debug_en = 1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (rd_en) begin
                n_rden++;
                if (first_addr < 0) first_addr = int'(rd_addr);
            end
            if (dump_done) n_done++;
            if (serial_out_valid) begin
                q_bits.push_back(serial_out);
                if (seen) n_gaps += since_valid;
                since_valid = 0;
                seen = 1;
            end else if (seen) since_valid++;
            if (hold) begin
                if (!hv_set) begin hv = serial_out; hv_set = 1; end
                else if (serial_out !== hv) hold_unstable++;
            end
            if (aborted) begin
                drop_cyc++;
                if (serial_out_valid && drop_cyc >= 3) late_valid++;
                if (drop_cyc >= 10) begin timed_out = 0; break; end
            end
            if (n_done > 0) begin
                post_done++;
                if (post_done >= 4) begin timed_out = 0; break; end
            end
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) hold = 0;
            end
            if (!hold_started && hold_at >= 0 && q_bits.size() == hold_at) begin
                hold = 1; hold_left = hold_len; hold_started = 1;
            end
            if (scramble && q_bits.size() == 3) begin
                sram_select = 2'($urandom); word_count = (AW+1)'($urandom); msb_first = 1'($urandom);
            end
            if (!aborted && abort_at >= 0 && q_bits.size() == abort_at) begin
                debug_en = 0; aborted = 1; drop_cyc = 0;
            end
        end
        end_addr = int'(rd_addr);
        debug_en = 0; hold = 0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; debug_en = 0; hold = 0; sram_select = 0; word_count = 0; msb_first = 0;
        repeat (3) @(negedge clk);
        n_tests++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
        n_tests++; if (rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr got %0h want 0", rd_addr); end
        n_tests++; if (serial_out !== 1'b0) begin n_fail++; $display("FAIL reset_serial_out got %b want 0", serial_out); end
        n_tests++; if (serial_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", serial_out_valid); end
        n_tests++; if (dump_done !== 1'b0) begin n_fail++; $display("FAIL reset_dump_done got %b want 0", dump_done); end
        rst_n = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lsb_first();
        mem[2][0] = 16'h1234; mem[2][1] = 16'hABCD;
        build_exp(2, 2, 0, 0);
        run_dump(2, 2, 0, -1, 0, -1, 0, 200);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL lsb_timeout got timeout want dump_done"); end
        n_tests++; if (q_bits.size() != 32) begin n_fail++; $display("FAIL lsb_bitcount got %0d want 32", q_bits.size()); end
        n_tests++; if (count_diff() != 0) begin n_fail++; $display("FAIL lsb_bits got %0d wrong bits want 0", count_diff()); end
        n_tests++; if (n_gaps != 0) begin n_fail++; $display("FAIL lsb_gaps got %0d want 0", n_gaps); end
        n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL lsb_done got %0d pulses want 1", n_done); end
        n_tests++; if (n_rden != 2) begin n_fail++; $display("FAIL lsb_rden got %0d want 2", n_rden); end
    endtask

    task automatic test_msb_first();
        bit first4 [4];
        run_dump(2, 2, 1, -1, 0, -1, 0, 200);
        for (int i = 0; i < 4; i++) first4[i] = (q_bits.size() > i) ? q_bits[i] : 1'bx;
        n_tests++;
        if (first4[0] !== 1'b0 || first4[1] !== 1'b0 || first4[2] !== 1'b0 || first4[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL msb_first4 got %b%b%b%b want 0001", first4[0], first4[1], first4[2], first4[3]);
        end
        build_exp(2, 2, 1, 0);
        n_tests++; if (q_bits.size() != 32 || count_diff() != 0) begin n_fail++;
            $display("FAIL msb_bits got %0d bits/%0d wrong want 32/0", q_bits.size(), count_diff()); end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) mem[1][i] = 16'($urandom);
        build_exp(1, 3, 0, 0);
        run_dump(1, 3, 0, 7, 5, -1, 0, 300);
        n_tests++; if (n_gaps != 5) begin n_fail++; $display("FAIL hold_gap got %0d want 5", n_gaps); end
        n_tests++; if (q_bits.size() != 48 || count_diff() != 0) begin n_fail++;
            $display("FAIL hold_bits got %0d bits/%0d wrong want 48/0", q_bits.size(), count_diff()); end
        n_tests++; if (hold_unstable != 0) begin n_fail++; $display("FAIL hold_stable got %0d changes want 0", hold_unstable); end
        // Hold raised while the prefetch for the third word is still in flight.
        build_exp(1, 3, 1, 0);
        run_dump(1, 3, 1, 28, 4, -1, 0, 300);
        n_tests++; if (n_gaps != 4) begin n_fail++; $display("FAIL hold_inflight_gap got %0d want 4", n_gaps); end
        n_tests++; if (q_bits.size() != 48 || count_diff() != 0) begin n_fail++;
            $display("FAIL hold_inflight_bits got %0d bits/%0d wrong want 48/0", q_bits.size(), count_diff()); end
        n_tests++; if (n_rden != 3 || n_done != 1) begin n_fail++;
            $display("FAIL hold_inflight_counts got rden=%0d done=%0d want 3/1", n_rden, n_done); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int sel = $urandom_range(0, 3);
            int wc  = $urandom_range(1, 6);
            bit msb = 1'($urandom);
            int hat = (it % 2 == 0) ? $urandom_range(1, wc*DW - 1) : -1;
            int hln = $urandom_range(1, 4);
            for (int c = 0; c < NC; c++) for (int a = 0; a < 8; a++) mem[c][a] = 16'($urandom);
            build_exp(sel, wc, msb, 0);
            run_dump(sel, wc, msb, hat, hln, -1, it % 2 == 1, 400);
            n_tests++; if (q_bits.size() != wc*DW || count_diff() != 0) begin n_fail++;
                $display("FAIL rand%0d_bits got %0d bits/%0d wrong want %0d/0", it, q_bits.size(), count_diff(), wc*DW); end
            n_tests++; if (n_gaps != ((hat >= 0) ? hln : 0)) begin n_fail++;
                $display("FAIL rand%0d_gaps got %0d want %0d", it, n_gaps, (hat >= 0) ? hln : 0); end
            n_tests++; if (n_rden != wc || n_done != 1) begin n_fail++;
                $display("FAIL rand%0d_counts got rden=%0d done=%0d want %0d/1", it, n_rden, n_done, wc); end
        end
    endtask

    task automatic test_zero_words();
        run_dump(0, 0, 0, -1, 0, -1, 0, 60);
        n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL zero_done got %0d want 1", n_done); end
        n_tests++; if (n_rden != 0) begin n_fail++; $display("FAIL zero_rden got %0d want 0", n_rden); end
        n_tests++; if (q_bits.size() != 0) begin n_fail++; $display("FAIL zero_valid got %0d bits want 0", q_bits.size()); end
    endtask

    task automatic test_abort_restart();
        for (int a = 0; a < 4; a++) mem[3][a] = 16'($urandom);
        build_exp(3, 4, 0, 0);
        run_dump(3, 4, 0, -1, 0, 7, 0, 200);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL abort_timeout got timeout want abort"); end
        n_tests++; if (late_valid != 0) begin n_fail++; $display("FAIL abort_valid got %0d late bits want 0", late_valid); end
        n_tests++; if (n_done != 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", n_done); end
        n_tests++; if (q_bits.size() < 7 || q_bits.size() > 9 || count_diff() != 0) begin n_fail++;
            $display("FAIL abort_prefix got %0d bits/%0d wrong want 7..9/0", q_bits.size(), count_diff()); end
        n_tests++; if (rd_addr !== '0) begin n_fail++; $display("FAIL abort_addr got %0h want 0", rd_addr); end
        build_exp(3, 2, 0, 0);
        run_dump(3, 2, 0, -1, 0, -1, 0, 200);
        n_tests++; if (first_addr != 0) begin n_fail++; $display("FAIL restart_addr got %0d want 0", first_addr); end
        n_tests++; if (q_bits.size() != 32 || count_diff() != 0 || n_done != 1) begin n_fail++;
            $display("FAIL restart_bits got %0d bits/%0d wrong done=%0d want 32/0/1", q_bits.size(), count_diff(), n_done); end
    endtask

    task automatic test_async_reset();
        int waited = 0;
        sram_select = 1; word_count = 3; msb_first = 0; debug_en = 1;
        while (waited < 60) begin
            @(negedge clk);
            waited++;
            if (serial_out_valid) break;
        end
        repeat (13) @(negedge clk);
        #2 rst_n = 0;
        #1;
        n_tests++; if (serial_out_valid !== 1'b0 || rd_en !== 1'b0 || dump_done !== 1'b0 || serial_out !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_outs got v=%b en=%b d=%b so=%b want 0000",
                               serial_out_valid, rd_en, dump_done, serial_out); end
        n_tests++; if (rd_addr !== '0) begin n_fail++; $display("FAIL async_reset_addr got %0h want 0", rd_addr); end
        repeat (2) @(negedge clk);
        rst_n = 1;
        // debug_en stayed high through reset, so a new dump must start on its own.
        for (int a = 0; a < 3; a++) mem[1][a] = 16'($urandom);
        build_exp(1, 2, 0, 0);
        run_dump(1, 2, 0, -1, 0, -1, 0, 200);
        n_tests++; if (q_bits.size() != 32 || count_diff() != 0 || n_done != 1) begin n_fail++;
            $display("FAIL en_through_reset got %0d bits/%0d wrong done=%0d want 32/0/1", q_bits.size(), count_diff(), n_done); end
    endtask

    task automatic test_full_memory();
        for (int a = 0; a < DEPTH; a++) mem[0][a] = 16'($urandom);
        build_exp(0, DEPTH, 1, 0);
        run_dump(0, DEPTH, 1, -1, 0, -1, 0, 70000);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL full_timeout got timeout want dump_done"); end
        n_tests++; if (q_bits.size() != DEPTH*DW) begin n_fail++; $display("FAIL full_bitcount got %0d want %0d", q_bits.size(), DEPTH*DW); end
        n_tests++; if (count_diff() != 0) begin n_fail++; $display("FAIL full_bits got %0d wrong want 0", count_diff()); end
        n_tests++; if (n_gaps != 0) begin n_fail++; $display("FAIL full_gaps got %0d want 0", n_gaps); end
        n_tests++; if (n_rden != DEPTH) begin n_fail++; $display("FAIL full_rden got %0d want %0d", n_rden, DEPTH); end
        n_tests++; if (end_addr != 0) begin n_fail++; $display("FAIL full_wrap got %0d want 0", end_addr); end
        n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL full_done got %0d want 1", n_done); end
    endtask

    initial begin
        for (int c = 0; c < NC; c++) for (int a = 0; a < DEPTH; a++) mem[c][a] = 16'($urandom);
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_hold();
        test_random();
        test_zero_words();
        test_abort_restart();
        test_async_reset();
        test_full_memory();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
